// File: rtl/pwr_seq_pkg.sv
// Shared state encoding and helpers for the rail power sequencer.
package pwr_seq_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_RAMP   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_ON     = 3'd3,
      ST_DOWN   = 3'd4,
      ST_FAULT  = 3'd5
   } pwr_state_e;

   localparam int MAX_RAILS = 32;

   // Lowest monitored rail whose power-good is low; 0 when none is.
   function automatic int lowest_zero(input logic [MAX_RAILS-1:0] pg_vec,
                                      input logic [MAX_RAILS-1:0] mask);
      lowest_zero = 0;
      for (int i = MAX_RAILS - 1; i >= 0; i--) begin
         if (mask[i] && !pg_vec[i]) lowest_zero = i;
      end
   endfunction

endpackage

// File: rtl/power_sequencer_pg_sync.sv
// Two-flop synchroniser bank for the asynchronous regulator power-good pins.
module pg_sync
   import pwr_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic [WIDTH-1:0] pg_raw,
   output logic [WIDTH-1:0] pg_s
);

   logic [WIDTH-1:0] pg_meta;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         pg_meta <= '0;
         pg_s    <= '0;
      end else begin
         pg_meta <= pg_raw;
         pg_s    <= pg_meta;
      end
   end

endmodule

// File: rtl/power_sequencer.sv
// Ordered rail bring-up / reverse shutdown with per-stage timeout, fault latch
// and delayed FPGA configuration release.
//
// state  | meaning
// OFF    | all rails disabled, waiting for pwr_req
// RAMP   | en[0..k] high, waiting for pg of stage k (timeout -> FAULT)
// SETTLE | pg of stage k seen, settle delay before next stage / ON
// ON     | all rails up; cfg_release after the configuration delay
// DOWN   | disabling stage k, one stage per off-delay, toward OFF
// FAULT  | all rails dropped at once, fault latched until cleared
module power_sequencer
   import pwr_seq_pkg::*;
#(
   parameter int N_RAILS         = 4,
   parameter int PG_TIMEOUT_CYC  = 5_000_000,
   parameter int STAGE_DELAY_CYC = 500_000,
   parameter int OFF_DELAY_CYC   = 250_000,
   parameter int CFG_DELAY_CYC   = 1_000_000
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset_n,
   input  logic                       pwr_req,
   input  logic                       clear_fault,
   input  logic [N_RAILS-1:0]         pg,
   output logic [N_RAILS-1:0]         en,
   output logic                       pwr_good,
   output logic                       cfg_release,
   output logic                       fault,
   output logic [$clog2(N_RAILS)-1:0] fault_stage,
   output logic [2:0]                 state_o
);

   localparam int K_W     = $clog2(N_RAILS);
   localparam int MAX_A   = (PG_TIMEOUT_CYC > STAGE_DELAY_CYC) ? PG_TIMEOUT_CYC : STAGE_DELAY_CYC;
   localparam int MAX_B   = (OFF_DELAY_CYC > CFG_DELAY_CYC) ? OFF_DELAY_CYC : CFG_DELAY_CYC;
   localparam int MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TMR_W   = $clog2(MAX_DLY) + 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N_RAILS - 1);

   pwr_state_e         state, state_nxt;
   logic [K_W-1:0]     k, k_nxt;
   logic [TMR_W-1:0]   tmr, tmr_nxt;
   logic               restart;
   logic [N_RAILS-1:0] pg_s, mon_mask, en_nxt;
   logic               mon_fail;
   logic [K_W-1:0]     fail_idx;
   logic               fault_nxt, pwr_good_nxt, cfg_release_nxt;
   logic [K_W-1:0]     fault_stage_nxt;

   pg_sync #(.WIDTH(N_RAILS)) u_pg_sync (
      .clk_sys (clk_clk),
      .rst_b   (reset_reset_n),
      .pg_raw  (pg),
      .pg_s    (pg_s)
   );

   // Rails that must already be good: those below k in RAMP, up to k in SETTLE.
   always_comb begin
      mon_mask = '0;
      for (int j = 0; j < N_RAILS; j++) begin
         case (state)
            ST_RAMP:   mon_mask[j] = (j < int'(k));
            ST_SETTLE: mon_mask[j] = (j <= int'(k));
            ST_ON:     mon_mask[j] = 1'b1;
            default:   mon_mask[j] = 1'b0;
         endcase
      end
   end

   assign mon_fail = |(mon_mask & ~pg_s);
   assign fail_idx = K_W'(lowest_zero(MAX_RAILS'(pg_s), MAX_RAILS'(mon_mask)));

   always_comb begin
      state_nxt       = state;
      k_nxt           = k;
      restart         = 1'b0;
      fault_nxt       = fault;
      fault_stage_nxt = fault_stage;
      case (state)
         ST_OFF: begin
            if (pwr_req && !fault) begin
               state_nxt = ST_RAMP;
               k_nxt     = '0;
            end
         end
         ST_RAMP: begin
            if (mon_fail) begin
               state_nxt       = ST_FAULT;
               fault_stage_nxt = fail_idx;
            end else if (tmr == TMR_W'(PG_TIMEOUT_CYC - 1)) begin
               state_nxt       = ST_FAULT;
               fault_stage_nxt = k;
            end else if (!pwr_req) begin
               state_nxt = ST_DOWN;
            end else if (pg_s[k]) begin
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (mon_fail) begin
               state_nxt       = ST_FAULT;
               fault_stage_nxt = fail_idx;
            end else if (!pwr_req) begin
               state_nxt = ST_DOWN;
            end else if (tmr == TMR_W'(STAGE_DELAY_CYC - 1)) begin
               if (k == K_LAST) begin
                  state_nxt = ST_ON;
               end else begin
                  state_nxt = ST_RAMP;
                  k_nxt     = k + K_W'(1);
               end
            end
         end
         ST_ON: begin
            if (mon_fail) begin
               state_nxt       = ST_FAULT;
               fault_stage_nxt = fail_idx;
            end else if (!pwr_req) begin
               state_nxt = ST_DOWN;
            end
         end
         ST_DOWN: begin
            if (tmr == TMR_W'(OFF_DELAY_CYC - 1)) begin
               if (k == '0) begin
                  state_nxt = ST_OFF;
               end else begin
                  k_nxt   = k - K_W'(1);
                  restart = 1'b1;
               end
            end
         end
         ST_FAULT: begin
            if (clear_fault && !pwr_req) begin
               state_nxt = ST_OFF;
               fault_nxt = 1'b0;
            end
         end
         default: state_nxt = ST_OFF;
      endcase

      if (state_nxt == ST_FAULT) fault_nxt = 1'b1;

      // Timer restarts on every state or stage entry; in ON it saturates at the cfg delay.
      if (restart || state_nxt != state) begin
         tmr_nxt = '0;
      end else if (state == ST_ON) begin
         tmr_nxt = (tmr < TMR_W'(CFG_DELAY_CYC)) ? tmr + TMR_W'(1) : tmr;
      end else if (state inside {ST_RAMP, ST_SETTLE, ST_DOWN}) begin
         tmr_nxt = tmr + TMR_W'(1);
      end else begin
         tmr_nxt = tmr;
      end

      en_nxt = '0;
      for (int i = 0; i < N_RAILS; i++) begin
         case (state_nxt)
            ST_RAMP, ST_SETTLE: en_nxt[i] = (i <= int'(k_nxt));
            ST_ON:              en_nxt[i] = 1'b1;
            ST_DOWN:            en_nxt[i] = (i < int'(k_nxt));
            default:            en_nxt[i] = 1'b0;
         endcase
      end

      pwr_good_nxt    = (state_nxt == ST_ON);
      cfg_release_nxt = (state_nxt == ST_ON) && (tmr_nxt >= TMR_W'(CFG_DELAY_CYC));
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state       <= ST_OFF;
         k           <= '0;
         tmr         <= '0;
         en          <= '0;
         pwr_good    <= 1'b0;
         cfg_release <= 1'b0;
         fault       <= 1'b0;
         fault_stage <= '0;
      end else begin
         state       <= state_nxt;
         k           <= k_nxt;
         tmr         <= tmr_nxt;
         en          <= en_nxt;
         pwr_good    <= pwr_good_nxt;
         cfg_release <= cfg_release_nxt;
         fault       <= fault_nxt;
         fault_stage <= fault_stage_nxt;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer: a regulator plant drives pg after random delays;
// expected event times come from the sequencing rules as plain arithmetic.
module tb_power_sequencer;

   localparam int N     = 4;
   localparam int PG_TO = 100;
   localparam int SD    = 10;
   localparam int OD    = 5;
   localparam int CD    = 20;
   localparam int W_EN = 0, W_PG = 1, W_CFG = 2, W_FLT = 3, W_ST = 4;

   logic         clk_clk = 1'b0;
   logic         reset_reset_n, pwr_req, clear_fault;
   logic [N-1:0] pg, en;
   logic         pwr_good, cfg_release, fault;
   logic [1:0]   fault_stage;
   logic [2:0]   state_o;

   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc      = 0;
   int           d[N];
   int           on_cnt[N];
   logic [N-1:0] kill;

   power_sequencer #(
      .N_RAILS         (N),
      .PG_TIMEOUT_CYC  (PG_TO),
      .STAGE_DELAY_CYC (SD),
      .OFF_DELAY_CYC   (OD),
      .CFG_DELAY_CYC   (CD)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .pwr_req       (pwr_req),
      .clear_fault   (clear_fault),
      .pg            (pg),
      .en            (en),
      .pwr_good      (pwr_good),
      .cfg_release   (cfg_release),
      .fault         (fault),
      .fault_stage   (fault_stage),
      .state_o       (state_o)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Regulator model: pg follows en after d[i] cycles unless the rail is killed.
   task automatic plant_eval();
      for (int i = 0; i < N; i++) pg[i] = en[i] && (on_cnt[i] > d[i]) && !kill[i];
   endtask

   task automatic step();
      @(posedge clk_clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) on_cnt[i] = (en[i] === 1'b1) ? on_cnt[i] + 1 : 0;
      plant_eval();
   endtask

   function automatic logic [31:0] sig_val(input int which);
      case (which)
         W_EN:    return 32'(en);
         W_PG:    return 32'(pwr_good);
         W_CFG:   return 32'(cfg_release);
         W_FLT:   return 32'(fault);
         W_ST:    return 32'(state_o);
         default: return 32'd0;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int which, input logic [31:0] val,
                           input int budget, output int t);
      int n;
      n = 0;
      while (sig_val(which) !== val && n < budget) begin
         step();
         n++;
      end
      if (sig_val(which) === val) begin
         t = cyc;
      end else begin
         t = -1;
         check_val({tag, "_wait"}, sig_val(which), val);
      end
   endtask

   // Stage k+1 rises d[k] + 2 (sync) + 1 (decision) + settle cycles after stage k.
   task automatic check_ramp(input int r, input int n_stg, output int last_rise);
      int exp_t, t;
      logic [N-1:0] m;
      exp_t     = r + 1;
      last_rise = -1;
      for (int k = 0; k < n_stg; k++) begin
         m = N'((1 << (k + 1)) - 1);
         wait_sig("en_rise", W_EN, 32'(m), 300, t);
         check_val($sformatf("en_rise%0d_time", k), t, exp_t);
         last_rise = exp_t;
         exp_t     = exp_t + d[k] + 3 + SD;
      end
   endtask

   task automatic ramp_full(input int r);
      int lr, t, exp_pg;
      check_ramp(r, N, lr);
      exp_pg = lr + d[N-1] + 3 + SD;
      wait_sig("pwr_good_up", W_PG, 1, 300, t);
      check_val("pwr_good_time", t, exp_pg);
      check_val("cfg_low_at_on", cfg_release, 0);
      wait_sig("cfg_up", W_CFG, 1, 100, t);
      check_val("cfg_release_time", t, exp_pg + CD);
      check_val("state_on", state_o, 3);
   endtask

   task automatic power_up(input bit rnd);
      for (int i = 0; i < N; i++) d[i] = rnd ? $urandom_range(1, 20) : 5;
      pwr_req = 1'b1;
      ramp_full(cyc);
   endtask

   task automatic shutdown();
      int s, t;
      logic [N-1:0] m;
      pwr_req = 1'b0;
      s = cyc;
      wait_sig("pg_drop", W_PG, 0, 10, t);
      check_val("pwr_good_drop_time", t, s + 1);
      check_val("cfg_drop", cfg_release, 0);
      for (int k = N - 1; k >= 0; k--) begin
         m = N'((1 << k) - 1);
         wait_sig("en_fall", W_EN, 32'(m), 20, t);
         check_val($sformatf("en_fall%0d_time", k), t, s + 1 + (N - 1 - k) * OD);
         if (k == N - 2) begin
            pwr_req = 1'b1;
            step();
            pwr_req = 1'b0;
         end
      end
      wait_sig("off", W_ST, 0, 20, t);
      check_val("off_time", t, s + 1 + N * OD);
   endtask

   task automatic brownout(output int exp_stage);
      int b, b2, t, t0;
      b  = $urandom_range(0, N - 1);
      b2 = $urandom_range(0, N - 1);
      kill    = '0;
      kill[b] = 1'b1;
      if ($urandom_range(0, 1) == 1) kill[b2] = 1'b1;
      exp_stage = (kill[b2] && b2 < b) ? b2 : b;
      plant_eval();
      t0 = cyc;
      step();
      kill = '0;
      plant_eval();
      wait_sig("fault_up", W_FLT, 1, 10, t);
      check_val("brownout_time", t, t0 + 3);
      check_val("brownout_stage", fault_stage, exp_stage);
      check_val("brownout_en", en, 0);
      check_val("brownout_pwr_good", pwr_good, 0);
      check_val("brownout_cfg", cfg_release, 0);
      check_val("brownout_state", state_o, 5);
   endtask

   task automatic fault_clear(input int exp_stage);
      clear_fault = 1'b1;
      step();
      clear_fault = 1'b0;
      step();
      check_val("clear_ignored_fault", fault, 1);
      check_val("clear_ignored_state", state_o, 5);
      pwr_req = 1'b0;
      step();
      clear_fault = 1'b1;
      step();
      clear_fault = 1'b0;
      check_val("cleared_fault", fault, 0);
      check_val("cleared_state", state_o, 0);
      check_val("cleared_stage_held", fault_stage, exp_stage);
   endtask

   initial begin
      int fs, ts, lr, t;
      reset_reset_n = 1'b0;
      pwr_req       = 1'b0;
      clear_fault   = 1'b0;
      pg            = '0;
      kill          = '0;
      for (int i = 0; i < N; i++) begin
         d[i]      = 5;
         on_cnt[i] = 0;
      end
      repeat (3) step();
      check_val("rst_en", en, 0);
      check_val("rst_pwr_good", pwr_good, 0);
      check_val("rst_cfg", cfg_release, 0);
      check_val("rst_fault", fault, 0);
      check_val("rst_stage", fault_stage, 0);
      check_val("rst_state", state_o, 0);
      reset_reset_n = 1'b1;
      step();

      power_up(1'b0);
      brownout(fs);
      fault_clear(fs);
      power_up(1'b1);
      shutdown();

      for (int i = 0; i < N; i++) d[i] = $urandom_range(1, 20);
      ts       = $urandom_range(1, N - 1);
      kill     = '0;
      kill[ts] = 1'b1;
      pwr_req  = 1'b1;
      check_ramp(cyc, ts + 1, lr);
      wait_sig("timeout_fault", W_FLT, 1, 200, t);
      check_val("timeout_time", t, lr + PG_TO);
      check_val("timeout_stage", fault_stage, ts);
      check_val("timeout_en", en, 0);
      kill    = '0;
      pwr_req = 1'b0;
      step();
      clear_fault = 1'b1;
      step();
      clear_fault = 1'b0;
      check_val("timeout_cleared_state", state_o, 0);

      for (int i = 0; i < N; i++) d[i] = $urandom_range(1, 20);
      pwr_req = 1'b1;
      check_ramp(cyc, 3, lr);
      step();
      #2;
      reset_reset_n = 1'b0;
      #1;
      check_val("midramp_rst_en", en, 0);
      check_val("midramp_rst_pwr_good", pwr_good, 0);
      check_val("midramp_rst_cfg", cfg_release, 0);
      check_val("midramp_rst_fault", fault, 0);
      check_val("midramp_rst_stage", fault_stage, 0);
      check_val("midramp_rst_state", state_o, 0);
      repeat (2) step();
      reset_reset_n = 1'b1;
      ramp_full(cyc);
      shutdown();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
